// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions: instruction kinds, opcode/funct constants
// and the loader FSM state type. The decoder uses the same constants.
package mips_pkg;

  typedef enum logic [2:0] {
    KIND_ADDU  = 3'd0,
    KIND_OR    = 3'd1,
    KIND_ADDIU = 3'd2,
    KIND_SW    = 3'd3,
    KIND_LW    = 3'd4,
    KIND_BNE   = 3'd5,
    KIND_JAL   = 3'd6,
    KIND_RSVD  = 3'd7
  } kind_t;

  localparam logic [5:0] OPCODE_SPECIAL = 6'h00;
  localparam logic [5:0] OPCODE_ADDIU   = 6'h09;
  localparam logic [5:0] OPCODE_SW      = 6'h2B;
  localparam logic [5:0] OPCODE_LW      = 6'h23;
  localparam logic [5:0] OPCODE_BNE     = 6'h05;
  localparam logic [5:0] OPCODE_JAL     = 6'h03;

  localparam logic [5:0] FUNC_ADDU      = 6'h21;
  localparam logic [5:0] FUNC_OR        = 6'h25;

  typedef enum logic [1:0] {
    ENC_IDLE = 2'd0,
    ENC_ENC  = 2'd1,
    ENC_WR   = 2'd2,
    ENC_DONE = 2'd3
  } enc_state_t;

  // R-type kinds are the only ones that carry an rd field.
  function automatic logic is_rtype(input kind_t k);
    return (k == KIND_ADDU) || (k == KIND_OR);
  endfunction

endpackage

// File: rtl/imem_encoder_loader_instr_pack.sv
// instr_pack: purely combinational packing of kind + fields into a 32-bit
// MIPS word. With ENCODER_CHECK_EN defined it also flags illegal requests
// (reserved kind, or a nonzero rd on an I/J kind).
module instr_pack
  import mips_pkg::*;
(
  input  logic [2:0]  i_kind,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word
`ifdef ENCODER_CHECK_EN
  ,
  output logic        o_illegal
`endif
);

  kind_t w_kind;
  assign w_kind = kind_t'(i_kind);

  // Field packing per instruction kind; reserved kind packs as a NOP.
  always_comb begin
    o_word = 32'h0000_0000;
    case (w_kind)
      KIND_ADDU:  o_word = {OPCODE_SPECIAL, i_rs, i_rt, i_rd, 5'd0, FUNC_ADDU};
      KIND_OR:    o_word = {OPCODE_SPECIAL, i_rs, i_rt, i_rd, 5'd0, FUNC_OR};
      KIND_ADDIU: o_word = {OPCODE_ADDIU, i_rs, i_rt, i_imm};
      KIND_SW:    o_word = {OPCODE_SW, i_rs, i_rt, i_imm};
      KIND_LW:    o_word = {OPCODE_LW, i_rs, i_rt, i_imm};
      KIND_BNE:   o_word = {OPCODE_BNE, i_rs, i_rt, i_imm};
      KIND_JAL:   o_word = {OPCODE_JAL, i_target};
      default:    o_word = 32'h0000_0000;
    endcase
  end

`ifdef ENCODER_CHECK_EN
  assign o_illegal = (w_kind == KIND_RSVD) || (!is_rtype(w_kind) && (i_rd != 5'd0));
`endif

endmodule

// File: rtl/imem_encoder_loader.sv
// imem_encoder_loader: accepts symbolic instructions over valid/ready,
// encodes each into a MIPS word and writes it to consecutive imem addresses.
// One word per three cycles: IDLE (handshake) -> ENC (pack) -> WR (strobe).
// Optional feature macro: ENCODER_CHECK_EN adds the sticky err output and
// drops illegal requests instead of writing them.
module imem_encoder_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic [ADDR_W:0]   count
`ifdef ENCODER_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LP_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   LP_CAP  = {1'b1, {ADDR_W{1'b0}}};

  enc_state_t        r_state;
  enc_state_t        w_next;
  logic              w_accept;
  logic              w_wr;
  logic              w_load;

  logic [2:0]        r_kind;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_rd;
  logic [15:0]       r_imm;
  logic [25:0]       r_target;
  logic              r_last;

  logic [31:0]       w_word;
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic              r_done;
  logic              r_full;

`ifdef ENCODER_CHECK_EN
  logic              w_illegal;
  logic              w_err_set;
  logic              r_err;
`endif

  instr_pack u_pack (
    .i_kind    (r_kind),
    .i_rs      (r_rs),
    .i_rt      (r_rt),
    .i_rd      (r_rd),
    .i_imm     (r_imm),
    .i_target  (r_target),
    .o_word    (w_word)
`ifdef ENCODER_CHECK_EN
    ,
    .o_illegal (w_illegal)
`endif
  );

  // Next-state and per-state strobes; restart overrides every transition.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_wr     = 1'b0;
    w_load   = 1'b0;
    case (r_state)
      ENC_IDLE: begin
        if (in_valid && !restart) begin
          w_accept = 1'b1;
          w_next   = ENC_ENC;
        end
      end
      ENC_ENC: begin
        w_load = 1'b1;
        w_next = ENC_WR;
`ifdef ENCODER_CHECK_EN
        if (w_illegal) begin
          w_load = 1'b0;
          w_next = r_last ? ENC_DONE : ENC_IDLE;
        end
`endif
      end
      ENC_WR: begin
        w_wr   = 1'b1;
        w_next = (r_last || (r_addr == LP_LAST)) ? ENC_DONE : ENC_IDLE;
      end
      ENC_DONE: w_next = ENC_DONE;
      default:  w_next = ENC_IDLE;
    endcase
    if (restart) w_next = ENC_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ENC_IDLE;
    else     r_state <= w_next;
  end

  // Field capture at handshake; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_kind   <= in_kind;
      r_rs     <= in_rs;
      r_rt     <= in_rt;
      r_rd     <= in_rd;
      r_imm    <= in_imm;
      r_target <= in_target;
      r_last   <= in_last;
    end
  end

`ifdef ENCODER_CHECK_EN
  assign w_err_set = (r_state == ENC_ENC) && w_illegal;
`endif

  // Write data, address, count and sticky flags; address moves only after
  // a completed write and never wraps past the last word.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_wdata <= 32'h0000_0000;
      r_addr  <= LP_BASE;
      r_count <= '0;
      r_done  <= 1'b0;
      r_full  <= 1'b0;
`ifdef ENCODER_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      if (w_load) r_wdata <= w_word;
      if (w_wr) begin
        if (r_count != LP_CAP) r_count <= r_count + (ADDR_W + 1)'(1);
        if (r_addr == LP_LAST) r_full <= 1'b1;
        if (w_next == ENC_DONE) r_done <= 1'b1;
        else                    r_addr <= r_addr + ADDR_W'(1);
      end
`ifdef ENCODER_CHECK_EN
      if (w_err_set) begin
        r_err <= 1'b1;
        if (w_next == ENC_DONE) r_done <= 1'b1;
      end
`endif
    end
  end

  assign in_ready   = (r_state == ENC_IDLE) && !restart;
  assign imem_we    = w_wr && !restart && !rst;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign busy       = (r_state == ENC_ENC) || (r_state == ENC_WR);
  assign done       = r_done;
  assign full       = r_full;
  assign count      = r_count;
`ifdef ENCODER_CHECK_EN
  assign err        = r_err;
`endif

endmodule
